ultrasonic_scan_ctrl: RTL
=========================

Name: ultrasonic_scan_ctrl

Overview:
- Round-robin scheduler that shares one distance-measurement engine among N HC-SR04 sensors.
- Fires one sensor at a time to prevent acoustic crosstalk and measures its echo pulse width in centimetre units.
- Detects a missing echo and an out-of-range echo, then enforces a guard gap before the next sensor fires.
- Sits between the sensor GPIO pins and the application logic (display, elevator/robot control), replacing free-running per-sensor trigger logic.

Parameters:
- N_SENS, 4, number of sensors (2..8).
- CH_W, 2, channel index width, equal to clog2(N_SENS).
- TRIG_CYC, 120, trig high time in clk cycles (10 us at 12 MHz).
- CM_DIV, 706, clk cycles of echo-high per 1 cm.
- MAX_CM, 400, range limit in cm.
- RISE_TO, 24000, max cycles from trig fall to echo rise (2 ms).
- GAP_CYC, 720000, guard time after each report (60 ms).

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  reset; asynchronous, active-high.
- run  in  1  1 = keep scanning.
- en_mask  in  N_SENS  per-sensor enable.
- echo  in  N_SENS  raw sensor echo pins (asynchronous).
- trig  out  N_SENS  sensor trigger pins.
- busy  out  1  high in any state other than IDLE.
- dist_valid  out  1  one-cycle strobe when a result is published.
- dist_ch  out  CH_W  channel of the published result.
- dist_cm  out  16  distance in cm.
- dist_err  out  1  1 = timeout or out of range.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - Outputs: trig=0, busy=0, dist_valid=0, dist_ch=0, dist_cm=0, dist_err=0.
  - Internal: state=IDLE, channel pointer=N_SENS-1, so the first selected channel is the lowest enabled index.
- Echo input path:
  - Every echo bit passes through a 2-flop synchronizer, then a third flop for edge detection.
  - Only the selected channel's bit is used. All other echo bits are ignored.
- Channel selection (done on leaving IDLE and on leaving GAP):
  - Pick the next enabled channel after the pointer, wrapping modulo N_SENS.
  - The pointer may select itself if it is the only enabled channel.
  - en_mask is sampled only at selection time.
- IDLE: when run=1 and en_mask!=0, select a channel and go to TRIG. Otherwise stay in IDLE.
- TRIG:
  - trig[ch]=1 for exactly TRIG_CYC cycles; all other trig bits stay 0.
  - Then go to WAIT_RISE and clear the timeout counter.
- WAIT_RISE:
  - A synchronized rising edge goes to MEASURE and clears the cycle counter and the cm counter.
  - After RISE_TO cycles with no edge, go to REPORT with dist_cm=0, err=1.
  - An echo already high on entry does not count as an edge, so a stuck-high echo times out.
- MEASURE:
  - The sub-counter counts cycles. At CM_DIV-1 it wraps to 0 and the cm counter increments.
  - Result is floor(high_cycles/CM_DIV).
  - A synchronized falling edge goes to REPORT with dist_cm=cm counter, err=0.
  - If the cm counter reaches MAX_CM while echo is still high, go to REPORT with dist_cm=MAX_CM, err=1. The remainder of that echo is ignored.
- REPORT:
  - Lasts one cycle with dist_valid=1.
  - dist_ch, dist_cm and dist_err are registered and then held until the next REPORT.
  - Then go to GAP.
- GAP:
  - Lasts GAP_CYC cycles with all trig bits at 0.
  - At the end: if run=1 and en_mask!=0, select a channel and go to TRIG. Otherwise go to IDLE.
- Latency:
  - Echo pin low ahead of clk edge k → dist_valid high in the cycle after edge k+2.
  - Rise and fall use identical synchronizer delay, so the measured width is exact to ±1 cycle.
- run deasserted mid-slot: the current slot completes (TRIG → ... → REPORT → GAP). No new trig fires afterwards.
- Reset mid-slot: trig drops immediately and all state returns to reset values. No partial report is produced.
- Width rules: counters are sized from the parameters (for example, GAP counter ≥ 20 bits). dist_cm is zero-extended to 16 bits.

Decomposition:
- Shared package (scan_pkg):
  - State encoding: IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP.
  - Default timing constants for 12 MHz.
  - A clog2 helper.
- One sub-module, echo_sync_edge:
  - N_SENS-wide 3-flop synchronizer.
  - Outputs rise and fall strobes.
- The FSM, counters and round-robin picker stay in the top module.

Test Plan:
- Single sensor, en_mask=0001, run=1, echo rises 6000 cycles after trig fall and stays high 7060 cycles → trig[0] high for exactly 120 cycles; dist_valid with ch=0, cm=10, err=0; next trig exactly 720000 cycles after the report.
- Width boundary: echo high 7059 cycles → cm=9. Echo high 706 cycles → cm=1. Echo high 705 cycles → cm=0, err=0.
- No echo on channel 2 → report ch=2, cm=0, err=1, exactly 24000 cycles after trig fall. Stuck-high echo gives the same result.
- Long echo (400×706+5000 cycles) → report cm=400, err=1 as soon as the limit is reached, without waiting for the echo fall.
- Round robin: en_mask=1011 with all echoes valid → trig order 0,1,3,0,1,3; changing the mask to 0100 during GAP makes the next selected channel 2.
- run=0 during MEASURE → report still produced, GAP completes, then IDLE with busy=0. Asserting rst during TRIG → trig drops to 0 within the same cycle and all outputs return to 0.

Source files
------------

// File: rtl/ultrasonic_scan_ctrl_pkg.sv
// Shared constants for the ultrasonic scan controller: FSM encoding, 12 MHz timing defaults, width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ultrasonic_scan_ctrl_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_REPORT    = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;

    // Timing defaults for a 12 MHz core clock
    localparam int TRIG_CYC_DEF = 120;     // 10 us trigger pulse
    localparam int CM_DIV_DEF   = 706;     // echo-high cycles per centimetre
    localparam int MAX_CM_DEF   = 400;     // sensor range limit
    localparam int RISE_TO_DEF  = 24000;   // 2 ms wait for echo rise
    localparam int GAP_CYC_DEF  = 720000;  // 60 ms acoustic guard gap

    // Bits needed to hold values 0..v-1, never less than one bit
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ultrasonic_scan_ctrl_if.sv
// Result bus from the scan controller to application logic.
// Latency: n/a (wires only).
// Backpressure: none; dist_valid is a single-cycle strobe, fields hold until the next report.
interface ultrasonic_scan_ctrl_if #(
    parameter int CH_W = 2
);
    logic            dist_valid;
    logic [CH_W-1:0] dist_ch;
    logic [15:0]     dist_cm;
    logic            dist_err;

    modport master (output dist_valid, dist_ch, dist_cm, dist_err);
    modport slave  (input  dist_valid, dist_ch, dist_cm, dist_err);
endinterface

// File: rtl/ultrasonic_scan_ctrl_echo_sync_edge.sv
// Synchronises raw echo pins (2 flops) and derives rise/fall strobes from a third flop.
// Latency: pin change appears as a strobe in the cycle after the second clock edge.
// Backpressure: none; strobes are single-cycle and unconditional.
module ultrasonic_scan_ctrl_echo_sync_edge #(
    parameter int N_SENS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SENS-1:0] echo_i,
    output logic [N_SENS-1:0] rise_o,
    output logic [N_SENS-1:0] fall_o
);

    logic [N_SENS-1:0] meta_q;
    logic [N_SENS-1:0] sync_q;
    logic [N_SENS-1:0] dly_q;

    // Two-flop synchroniser followed by one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rise_o = sync_q & ~dly_q;
    assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin HC-SR04 scheduler: triggers one sensor at a time, measures echo width in cm, then guards a gap.
// Latency: echo fall at the pin to dist_valid is three clock edges; timeout reports RISE_TO cycles after trig fall.
// Backpressure: none; results are single-cycle strobes with held fields, the consumer must keep up.
module ultrasonic_scan_ctrl
    import ultrasonic_scan_ctrl_pkg::*;
#(
    parameter int N_SENS   = 4,
    parameter int CH_W     = 2,
    parameter int TRIG_CYC = TRIG_CYC_DEF,
    parameter int CM_DIV   = CM_DIV_DEF,
    parameter int MAX_CM   = MAX_CM_DEF,
    parameter int RISE_TO  = RISE_TO_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_i,
    input  logic [N_SENS-1:0]     en_mask_i,
    input  logic [N_SENS-1:0]     echo_i,
    output logic [N_SENS-1:0]     trig_o,
    output logic                  busy_o,
    ultrasonic_scan_ctrl_if.master res_if
);

    // One shared timer covers the trigger pulse, the rise timeout and the guard gap
    localparam int TMR_MAX = (GAP_CYC > RISE_TO) ? ((GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC)
                                                 : ((RISE_TO > TRIG_CYC) ? RISE_TO : TRIG_CYC);
    localparam int TMR_W   = clog2_min1(TMR_MAX);
    localparam int SUB_W   = clog2_min1(CM_DIV);
    localparam int CM_W    = clog2_min1(MAX_CM + 1);

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [CM_W-1:0]   cm_q, cm_d;
    logic              dv_q, dv_d;
    logic [CH_W-1:0]   dch_q, dch_d;
    logic [15:0]       dcm_q, dcm_d;
    logic              derr_q, derr_d;

    logic [N_SENS-1:0] rise_w;
    logic [N_SENS-1:0] fall_w;
    logic              rise_sel;
    logic              fall_sel;
    logic              sub_wrap;
    logic              can_start;
    logic [CH_W-1:0]   nxt_ch;
    int                idx;

    ultrasonic_scan_ctrl_echo_sync_edge #(
        .N_SENS (N_SENS)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .echo_i (echo_i),
        .rise_o (rise_w),
        .fall_o (fall_w)
    );

    assign rise_sel  = rise_w[ch_q];
    assign fall_sel  = fall_w[ch_q];
    assign sub_wrap  = (sub_q == SUB_W'(CM_DIV - 1));
    assign can_start = run_i && (|en_mask_i);
    assign busy_o    = (state_q != S_IDLE);

    assign res_if.dist_valid = dv_q;
    assign res_if.dist_ch    = dch_q;
    assign res_if.dist_cm    = dcm_q;
    assign res_if.dist_err   = derr_q;

    // Only the active channel's trigger pin is driven, and only while in TRIG
    always_comb begin
        trig_o = '0;
        if (state_q == S_TRIG) begin
            trig_o[ch_q] = 1'b1;
        end
    end

    // Next enabled channel after the pointer; scanning farthest-first lets the nearest win, the pointer itself last
    always_comb begin
        nxt_ch = ch_q;
        idx    = 0;
        for (int i = N_SENS; i >= 1; i--) begin
            idx = int'(ch_q) + i;
            if (idx >= N_SENS) begin
                idx = idx - N_SENS;
            end
            if (en_mask_i[CH_W'(idx)]) begin
                nxt_ch = CH_W'(idx);
            end
        end
    end

    // Scan sequencer: trigger, wait for echo, measure, publish, guard gap
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tmr_d   = tmr_q + 1'b1;
        sub_d   = sub_q;
        cm_d    = cm_q;
        dv_d    = 1'b0;
        dch_d   = dch_q;
        dcm_d   = dcm_q;
        derr_d  = derr_q;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (can_start) begin
                    state_d = S_TRIG;
                    ch_d    = nxt_ch;
                end
            end
            S_TRIG: begin
                if (tmr_q == TMR_W'(TRIG_CYC - 1)) begin
                    state_d = S_WAIT_RISE;
                    tmr_d   = '0;
                end
            end
            S_WAIT_RISE: begin
                if (rise_sel) begin
                    state_d = S_MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (tmr_q == TMR_W'(RISE_TO - 1)) begin
                    state_d = S_REPORT;
                    dv_d    = 1'b1;
                    dch_d   = ch_q;
                    dcm_d   = '0;
                    derr_d  = 1'b1;
                end
            end
            S_MEASURE: begin
                if (fall_sel) begin
                    // The fall cycle is the last echo-high cycle seen by the synchroniser, so it is counted too
                    state_d = S_REPORT;
                    dv_d    = 1'b1;
                    dch_d   = ch_q;
                    dcm_d   = 16'(cm_q) + 16'(sub_wrap);
                    derr_d  = 1'b0;
                end else if (sub_wrap) begin
                    sub_d = '0;
                    cm_d  = cm_q + 1'b1;
                    if (cm_q == CM_W'(MAX_CM - 1)) begin
                        state_d = S_REPORT;
                        dv_d    = 1'b1;
                        dch_d   = ch_q;
                        dcm_d   = 16'(MAX_CM);
                        derr_d  = 1'b1;
                    end
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
            S_REPORT: begin
                state_d = S_GAP;
                tmr_d   = '0;
            end
            S_GAP: begin
                if (tmr_q == TMR_W'(GAP_CYC - 1)) begin
                    tmr_d = '0;
                    if (can_start) begin
                        state_d = S_TRIG;
                        ch_d    = nxt_ch;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and published result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= CH_W'(N_SENS - 1);
            tmr_q   <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            dv_q    <= 1'b0;
            dch_q   <= '0;
            dcm_q   <= '0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tmr_q   <= tmr_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            dv_q    <= dv_d;
            dch_q   <= dch_d;
            dcm_q   <= dcm_d;
            derr_q  <= derr_d;
        end
    end

endmodule
